// File: rtl/ip_tile_bitwise_shifter_fsm_if.sv
// ip_tile CSR + data-register bundle for the bitwise/shift tile.
// The master side is the host (drives the command and operands); the slave side is the IP.
interface ip_tile_bitwise_shifter_fsm_if #(
  parameter int unsigned CSR_IN_WIDTH  = 16,
  parameter int unsigned CSR_OUT_WIDTH = 16,
  parameter int unsigned REG_WIDTH     = 32
);
  logic [CSR_IN_WIDTH-1:0]  csr_in;
  logic                     csr_in_re;
  logic [REG_WIDTH-1:0]     data_reg_a;
  logic [REG_WIDTH-1:0]     data_reg_b;
  logic [CSR_OUT_WIDTH-1:0] csr_out;
  logic                     csr_out_we;
  logic [REG_WIDTH-1:0]     data_reg_c;

  modport master (
    output csr_in, data_reg_a, data_reg_b,
    input  csr_in_re, csr_out, csr_out_we, data_reg_c
  );

  modport slave (
    input  csr_in, data_reg_a, data_reg_b,
    output csr_in_re, csr_out, csr_out_we, data_reg_c
  );
endinterface

// File: rtl/ip_tile_bitwise_shifter_fsm.sv
// Registered bitwise-logic / shift unit for an ip_tile slot.
// Command csr_in: [15]=start, [10:8]=op, [4:0]=shift amount. Status csr_out: [0]=done, [1]=busy, [10:8]=op.
// Build option BARREL_SHIFT_EN: shifts/rotates finish in one EXEC cycle via a barrel shifter;
// otherwise they step one bit per EXEC cycle.
module ip_tile_bitwise_shifter_fsm #(
  parameter int unsigned CSR_IN_WIDTH  = 16,
  parameter int unsigned CSR_OUT_WIDTH = 16,
  parameter int unsigned REG_WIDTH     = 32
) (
  input logic                          clk,
  input logic                          arst_n,
  ip_tile_bitwise_shifter_fsm_if.slave bus
);

  localparam int unsigned SHAMT_W   = $clog2(REG_WIDTH);
  localparam int unsigned START_BIT = 15;
  localparam int unsigned OP_LSB    = 8;
  localparam int unsigned OP_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_DONE,
    ST_WAIT_CLR
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_SAR = 3'b110,
    OP_ROL = 3'b111
  } op_e;

  state_e                   state_q, state_d;
  op_e                      op_q, op_d;
  logic [REG_WIDTH-1:0]     acc_q, acc_d;
  logic [REG_WIDTH-1:0]     b_q, b_d;
  logic [SHAMT_W-1:0]       cnt_q, cnt_d;
  logic                     csr_in_re_q, csr_in_re_d;
  logic                     csr_out_we_q, csr_out_we_d;
  logic [CSR_OUT_WIDTH-1:0] csr_out_q, csr_out_d;
  logic [REG_WIDTH-1:0]     data_reg_c_q, data_reg_c_d;

  logic                     start;
  op_e                      op_in;
  logic [SHAMT_W-1:0]       n_in;
  logic                     unused_csr_bits;

  assign start           = bus.csr_in[START_BIT];
  assign op_in           = op_e'(bus.csr_in[OP_LSB +: OP_W]);
  assign n_in            = bus.csr_in[SHAMT_W-1:0];
  assign unused_csr_bits = ^{bus.csr_in[14:11], bus.csr_in[7:SHAMT_W]};

  // Status word: op echo plus busy/done flags, all other bits zero.
  function automatic logic [CSR_OUT_WIDTH-1:0] status_word(input op_e op, input logic busy,
                                                           input logic done);
    logic [CSR_OUT_WIDTH-1:0] s;
    s                  = '0;
    s[OP_LSB +: OP_W]  = op;
    s[1]               = busy;
    s[0]               = done;
    return s;
  endfunction

`ifdef BARREL_SHIFT_EN
  // Full-distance shift/rotate in one pass; rotate takes the upper half of a doubled word.
  function automatic logic [REG_WIDTH-1:0] barrel(input op_e op, input logic [REG_WIDTH-1:0] a,
                                                  input logic [SHAMT_W-1:0] n);
    logic [2*REG_WIDTH-1:0] dbl;
    dbl = {a, a} << n;
    case (op)
      OP_SHL:  return a << n;
      OP_SHR:  return a >> n;
      OP_SAR:  return REG_WIDTH'($signed(a) >>> n);
      default: return dbl[2*REG_WIDTH-1:REG_WIDTH];
    endcase
  endfunction
`else
  // Single-bit step of the selected shift/rotate.
  function automatic logic [REG_WIDTH-1:0] step1(input op_e op, input logic [REG_WIDTH-1:0] a);
    case (op)
      OP_SHL:  return {a[REG_WIDTH-2:0], 1'b0};
      OP_SHR:  return {1'b0, a[REG_WIDTH-1:1]};
      OP_SAR:  return {a[REG_WIDTH-1], a[REG_WIDTH-1:1]};
      default: return {a[REG_WIDTH-2:0], a[REG_WIDTH-1]};
    endcase
  endfunction
`endif

  // Next-state and next-register values; pulses default low, everything else holds.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    acc_d        = acc_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    csr_in_re_d  = 1'b0;
    csr_out_we_d = 1'b0;
    csr_out_d    = csr_out_q;
    data_reg_c_d = data_reg_c_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        csr_in_re_d = 1'b1;
        acc_d       = bus.data_reg_a;
        b_d         = bus.data_reg_b;
        op_d        = op_in;
        cnt_d       = n_in;
        csr_out_d   = status_word(op_in, 1'b1, 1'b0);
        state_d     = ST_EXEC;
      end

      ST_EXEC: begin
        case (op_q)
          OP_AND: begin acc_d = acc_q & b_q; state_d = ST_DONE; end
          OP_OR:  begin acc_d = acc_q | b_q; state_d = ST_DONE; end
          OP_XOR: begin acc_d = acc_q ^ b_q; state_d = ST_DONE; end
          OP_NOT: begin acc_d = ~acc_q;      state_d = ST_DONE; end
          default: begin
`ifdef BARREL_SHIFT_EN
            acc_d   = barrel(op_q, acc_q, cnt_q);
            state_d = ST_DONE;
`else
            // n=0 still spends one EXEC cycle and leaves A untouched.
            if (cnt_q == '0) begin
              state_d = ST_DONE;
            end else begin
              acc_d = step1(op_q, acc_q);
              cnt_d = cnt_q - SHAMT_W'(1);
              if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
            end
`endif
          end
        endcase
      end

      ST_DONE: begin
        data_reg_c_d = acc_q;
        csr_out_d    = status_word(op_q, 1'b0, 1'b1);
        csr_out_we_d = 1'b1;
        state_d      = ST_WAIT_CLR;
      end

      ST_WAIT_CLR: begin
        // Start must drop before another command is accepted.
        if (!start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_AND;
      acc_q        <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      csr_in_re_q  <= 1'b0;
      csr_out_we_q <= 1'b0;
      csr_out_q    <= '0;
      data_reg_c_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      csr_in_re_q  <= csr_in_re_d;
      csr_out_we_q <= csr_out_we_d;
      csr_out_q    <= csr_out_d;
      data_reg_c_q <= data_reg_c_d;
    end
  end

  assign bus.csr_in_re  = csr_in_re_q;
  assign bus.csr_out_we = csr_out_we_q;
  assign bus.csr_out    = csr_out_q;
  assign bus.data_reg_c = data_reg_c_q;

endmodule

// File: tb/tb_ip_tile_bitwise_shifter_fsm.sv
// Self-checking bench for ip_tile_bitwise_shifter_fsm: vector table + result scoreboard,
// plus hand sequences for held start and reset during EXEC.
module tb_ip_tile_bitwise_shifter_fsm;

  logic clk;
  logic arst_n;

  ip_tile_bitwise_shifter_fsm_if bus_if ();

  ip_tile_bitwise_shifter_fsm dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] csr;
    logic [31:0] exp_c;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [15:0] s;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   re_cnt = 0;
  int   we_cnt = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus_if.csr_in_re)  re_cnt <= re_cnt + 1;
    if (bus_if.csr_out_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Independent reference model (loop-based for the shift family).
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [15:0] csr);
    logic [2:0]  op;
    int          n;
    logic [31:0] r;
    op = csr[10:8];
    n  = int'(csr[4:0]);
    r  = a;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};
      3'd5: for (int i = 0; i < n; i++) r = {1'b0, r[31:1]};
      3'd6: for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
      default: for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
    endcase
    return r;
  endfunction

  // Edges from the start-sampling edge to the csr_out_we edge.
  function automatic int exp_lat(input logic [15:0] csr);
    int n;
    n = int'(csr[4:0]);
    if (csr[10] == 1'b0) return 3;
`ifdef BARREL_SHIFT_EN
    return 3;
`else
    return 3 + ((n == 0) ? 1 : n) - 1;
`endif
  endfunction

  // Issue one command, scoreboard its result, hold start for 'hold' cycles, then release.
  task automatic run_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] csr, input logic [31:0] exp_c, input int hold);
    exp_t        e;
    exp_t        got_e;
    logic [15:0] exp_s;
    logic [15:0] busy_s;
    logic [15:0] r;
    int          cyc;
    bit          got;
    int          re0;
    int          we0;
    exp_s  = {5'b0, csr[10:8], 6'b0, 2'b01};
    busy_s = {5'b0, csr[10:8], 6'b0, 2'b10};
    e.c    = exp_c;
    e.s    = exp_s;
    sb_q.push_back(e);
    @(posedge clk);
    re0 = re_cnt;
    we0 = we_cnt;
    #1;
    bus_if.data_reg_a = a;
    bus_if.data_reg_b = b;
    bus_if.csr_in     = csr;
    cyc = 0;
    got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 2) begin
        chk({tag, " csr_in_re"}, 32'(bus_if.csr_in_re), 32'd1);
        chk({tag, " busy"}, 32'(bus_if.csr_out), 32'(busy_s));
        // Operands and command are latched; disturbing them must not matter.
        r = 16'($urandom_range(0, 32767));
        bus_if.csr_in     = {1'b1, r[14:0]};
        bus_if.data_reg_a = $urandom;
        bus_if.data_reg_b = $urandom;
      end
      if (bus_if.csr_out_we) begin
        got = 1;
        if (sb_q.size() == 0) begin
          chk({tag, " unexpected result"}, 32'd1, 32'd0);
        end else begin
          got_e = sb_q.pop_front();
          chk({tag, " data_reg_c"}, bus_if.data_reg_c, got_e.c);
          chk({tag, " csr_out"}, 32'(bus_if.csr_out), 32'(got_e.s));
        end
        chk({tag, " latency"}, 32'(cyc - 1), 32'(exp_lat(csr)));
      end
    end
    if (!got) chk({tag, " timeout"}, 32'(cyc), 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk({tag, " hold c"}, bus_if.data_reg_c, exp_c);
    chk({tag, " hold s"}, 32'(bus_if.csr_out), 32'(exp_s));
    @(posedge clk);
    #1;
    bus_if.csr_in = 16'h0000;
    repeat (3) @(posedge clk);
    chk({tag, " re pulses"}, 32'(re_cnt - re0), 32'd1);
    chk({tag, " we pulses"}, 32'(we_cnt - we0), 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    int   we0;
    int   abort_cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [15:0] rc;
    logic [2:0]  rop;

    vecs[0]  = '{32'hA5A5A5A5, 32'h12A2A3A5, 16'h81F5, 32'hB7A7A7A5};
    vecs[1]  = '{32'hA5A5A5A5, 32'h12A2A3A5, 16'h80E0, 32'h00A0A1A5};
    vecs[2]  = '{32'hA5A5A5A5, 32'h12A2A3A5, 16'hFA00, 32'hB7070600};
    vecs[3]  = '{32'hA5A5A5A5, 32'h12A2A3A5, 16'h8300, 32'h5A5A5A5A};
    vecs[4]  = '{32'hA5A5A5A5, 32'h00000000, 16'h8404, 32'h5A5A5A50};
    vecs[5]  = '{32'hA5A5A5A5, 32'h00000000, 16'h8515, 32'h0000052D};
    vecs[6]  = '{32'hA5A5A5A5, 32'h00000000, 16'h8604, 32'hFA5A5A5A};
    vecs[7]  = '{32'h12A2A3A5, 32'h00000000, 16'h8708, 32'hA2A3A512};
    vecs[8]  = '{32'hA5A5A5A5, 32'hFFFFFFFF, 16'h8400, 32'hA5A5A5A5};
    vecs[9]  = '{32'h80000001, 32'h00000000, 16'h871F, 32'hC0000000};
    vecs[10] = '{32'h00000003, 32'h00000000, 16'h841F, 32'h80000000};
    vecs[11] = '{32'h80000000, 32'h00000000, 16'h861F, 32'hFFFFFFFF};
    vecs[12] = '{32'h80000000, 32'h00000000, 16'h8501, 32'h40000000};
    vecs[13] = '{32'hF0000001, 32'h00000000, 16'h8600, 32'hF0000001};

    arst_n            = 1'b0;
    bus_if.csr_in     = 16'h0000;
    bus_if.data_reg_a = 32'h0;
    bus_if.data_reg_b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset csr_in_re", 32'(bus_if.csr_in_re), 32'd0);
    chk("reset csr_out_we", 32'(bus_if.csr_out_we), 32'd0);
    chk("reset csr_out", 32'(bus_if.csr_out), 32'd0);
    chk("reset data_reg_c", bus_if.data_reg_c, 32'd0);
    arst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].csr, vecs[i].exp_c, 2);

    // Random commands against the loop model.
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      rc  = {1'b1, 4'($urandom_range(0, 15)), rop, 3'b000, 5'($urandom_range(0, 31))};
      run_cmd($sformatf("rnd%0d", i), ra, rb, rc, model(ra, rb, rc), 1);
    end

    // Start held for 20 cycles after completion: still one capture, one result.
    run_cmd("held", 32'hA5A5A5A5, 32'h12A2A3A5, 16'h81F5, 32'hB7A7A7A5, 20);

    // Reset during EXEC of SHR 21: outputs clear at once and no result is ever posted.
`ifdef BARREL_SHIFT_EN
    abort_cyc = 2;
`else
    abort_cyc = 8;
`endif
    @(posedge clk);
    we0 = we_cnt;
    #1;
    bus_if.data_reg_a = 32'hA5A5A5A5;
    bus_if.csr_in     = 16'h8515;
    repeat (abort_cyc) @(posedge clk);
    @(negedge clk);
    chk("pre-abort busy", 32'(bus_if.csr_out), 32'h0502);
    arst_n = 1'b0;
    #1;
    chk("abort csr_in_re", 32'(bus_if.csr_in_re), 32'd0);
    chk("abort csr_out_we", 32'(bus_if.csr_out_we), 32'd0);
    chk("abort csr_out", 32'(bus_if.csr_out), 32'd0);
    chk("abort data_reg_c", bus_if.data_reg_c, 32'd0);
    bus_if.csr_in = 16'h0000;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (30) @(posedge clk);
    chk("abort no result", 32'(we_cnt - we0), 32'd0);
    run_cmd("post-reset", 32'hA5A5A5A5, 32'h12A2A3A5, 16'h81F5, 32'hB7A7A7A5, 2);

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
